// File: rtl/aes_decipher_block_pkg.sv
// Shared AES definitions for the decipher block: key-length codes, round counts,
// FSM/update encodings and the GF(2^8) inverse-round helper functions.
package aes_decipher_block_pkg;

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_INIT  = 3'd1,
    CTRL_SBOX  = 3'd2,
    CTRL_MAIN  = 3'd3,
    CTRL_FINAL = 3'd4
  } ctrl_e;

  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } upd_e;

  function automatic logic [3:0] num_rounds(input logic kl);
    return (kl == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] b);
    return gm2(gm2(b));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] b);
    return gm2(gm4(b));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm8(b) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm8(b) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ gm2(b);
  endfunction

  // One column: byte 0 (row 0) is the MSB of the word.
  function automatic aes_word_t inv_mix_word(input aes_word_t w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
            gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t b);
    return {inv_mix_word(b[127:96]), inv_mix_word(b[95:64]),
            inv_mix_word(b[63:32]),  inv_mix_word(b[31:0])};
  endfunction

  // Row r rotates right by r columns.
  function automatic aes_block_t inv_shift_rows(input aes_block_t b);
    return {b[127:120], b[23:16],   b[47:40],   b[71:64],
            b[95:88],   b[119:112], b[15:8],    b[39:32],
            b[63:56],   b[87:80],   b[111:104], b[7:0],
            b[31:24],   b[55:48],   b[79:72],   b[103:96]};
  endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Connection bundle between the AES core and the decipher block: start/ready handshake,
// key-memory lookup and the shared inverse S-box word path.
interface aes_decipher_block_if;
  import aes_decipher_block_pkg::*;

  logic       next;
  logic       keylen;
  logic [3:0] round;
  aes_block_t round_key;
  aes_word_t  sboxw;
  aes_word_t  new_sboxw;
  aes_block_t block;
  aes_block_t new_block;
  logic       ready;

  modport master (
    output next, keylen, round_key, new_sboxw, block,
    input  round, sboxw, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, new_sboxw, block,
    output round, sboxw, new_block, ready
  );
endinterface

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher; InvSubBytes runs one 32-bit word per cycle
// through an external inverse S-box shared with the rest of the core.
module aes_decipher_block
  import aes_decipher_block_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  aes_decipher_block_if.slave bus
);

  ctrl_e      ctrl_q, ctrl_d;
  upd_e       upd;
  logic [3:0] round_q, round_d;
  logic [1:0] sword_q, sword_d;
  logic       keylen_q, keylen_d;
  logic       ready_q, ready_d;
  aes_block_t state_q, state_d;
  aes_word_t  sboxw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ctrl_q <= CTRL_IDLE;
    else          ctrl_q <= ctrl_d;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      CTRL_IDLE:  if (bus.next) ctrl_d = CTRL_INIT;
      CTRL_INIT:  ctrl_d = CTRL_SBOX;
      CTRL_SBOX:  if (sword_q == 2'd3) ctrl_d = (round_q == 4'd0) ? CTRL_FINAL : CTRL_MAIN;
      CTRL_MAIN:  ctrl_d = CTRL_SBOX;
      CTRL_FINAL: ctrl_d = CTRL_IDLE;
      default:    ctrl_d = CTRL_IDLE;
    endcase
  end

  // Counter and handshake updates; round_q doubles as the key-memory index.
  always_comb begin
    upd      = UPD_NONE;
    round_d  = round_q;
    sword_d  = sword_q;
    keylen_d = keylen_q;
    ready_d  = ready_q;
    case (ctrl_q)
      CTRL_IDLE: begin
        if (bus.next) begin
          round_d  = num_rounds(bus.keylen);
          keylen_d = bus.keylen;
          ready_d  = 1'b0;
        end
      end
      CTRL_INIT: begin
        upd     = UPD_INIT;
        round_d = num_rounds(keylen_q) - 4'd1;
        sword_d = 2'd0;
      end
      CTRL_SBOX: begin
        upd     = UPD_SBOX;
        sword_d = sword_q + 2'd1;
      end
      CTRL_MAIN: begin
        upd     = UPD_MAIN;
        round_d = round_q - 4'd1;
      end
      CTRL_FINAL: begin
        upd     = UPD_FINAL;
        ready_d = 1'b1;
      end
      default: upd = UPD_NONE;
    endcase
  end

  // Word sword_q sits at bit offset (3 - sword_q) * 32 of the packed state.
  always_comb begin
    state_d = state_q;
    sboxw   = '0;
    case (upd)
      UPD_INIT:  state_d = inv_shift_rows(bus.block ^ bus.round_key);
      UPD_SBOX: begin
        sboxw                           = state_q[{~sword_q, 5'd0} +: 32];
        state_d[{~sword_q, 5'd0} +: 32] = bus.new_sboxw;
      end
      UPD_MAIN:  state_d = inv_shift_rows(inv_mix_columns(state_q ^ bus.round_key));
      UPD_FINAL: state_d = state_q ^ bus.round_key;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_q  <= 4'd0;
      sword_q  <= 2'd0;
      keylen_q <= AES_128_BIT_KEY;
      ready_q  <= 1'b1;
      state_q  <= '0;
    end else begin
      round_q  <= round_d;
      sword_q  <= sword_d;
      keylen_q <= keylen_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
    end
  end

  assign bus.round     = round_q;
  assign bus.sboxw     = sboxw;
  assign bus.new_block = state_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: acts as the parent core (key memory + inverse S-box)
// and compares results with a byte-level textbook InvCipher model.
module tb_aes_decipher_block;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [16];

  aes_decipher_block_if dif();

  aes_decipher_block dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif)
  );

  always #5 clk = ~clk;

  assign dif.round_key = rk[dif.round];
  assign dif.new_sboxw = {isbox[dif.sboxw[31:24]], isbox[dif.sboxw[23:16]],
                          isbox[dif.sboxw[15:8]],  isbox[dif.sboxw[7:0]]};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, inv, s;
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = xb;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input bit kl);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Byte k of a block is row k%4 of column k/4.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input bit kl);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  acc;
    logic [31:0] coefs;
    int nr;
    coefs = 32'h0e0b0d09;
    nr = kl ? 14 : 10;
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8*k -: 8] ^ rk[nr][127 - 8*k -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c + row] = isbox[s[4*((c - row + 4) % 4) + row]];
      for (int k = 0; k < 16; k++) s[k] = t[k] ^ rk[r][127 - 8*k -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
              acc = acc ^ gmul(coefs[31 - 8*((j - row + 4) % 4) -: 8], s[4*c + j]);
            t[4*c + row] = acc;
          end
        s = t;
      end
    end
    for (int k = 0; k < 16; k++) ref_decrypt[127 - 8*k -: 8] = s[k];
  endfunction

  // Starts an op at #1 after an edge and returns #1 after the edge where ready rises.
  task automatic run_op(input logic [127:0] ct, input bit kl, input bit trace,
                        input bit disturb, input logic [127:0] exp_pt);
    int lat, nr, k;
    bit done;
    nr = kl ? 14 : 10;
    dif.block  = ct;
    dif.keylen = kl;
    dif.next   = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      dif.next = 1'b0;
      if (disturb && (lat == 5 || lat == 30 || lat == 5*nr + 1)) begin
        dif.next   = 1'b1;
        dif.keylen = ~kl;
      end
      if (dif.ready) done = 1'b1;
      else if (trace) begin
        k = lat - 2;
        if (lat == 1) begin
          check_eq("round_init", 128'(dif.round), 128'(nr));
          check_eq("sboxw_init", 128'(dif.sboxw), 128'd0);
        end else begin
          check_eq("round_trace", 128'(dif.round), 128'(nr - 1 - k/5));
          if (k % 5 == 4) check_eq("sboxw_zero", 128'(dif.sboxw), 128'd0);
        end
      end
    end
    dif.next = 1'b0;
    check_eq("latency", 128'(lat), kl ? 128'd72 : 128'd52);
    check_eq("plaintext", dif.new_block, exp_pt);
    if (disturb) begin
      @(posedge clk); #1;
      check_eq("no_restart", 128'(dif.ready), 128'd1);
      check_eq("hold_after_next", dif.new_block, exp_pt);
    end
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] ct;
    bit kl;
    int gap;

    dif.next   = 1'b0;
    dif.keylen = 1'b0;
    dif.block  = '0;
    build_tables();

    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_ready", 128'(dif.ready), 128'd1);
    check_eq("rst_block", dif.new_block, 128'd0);
    check_eq("rst_round", 128'(dif.round), 128'd0);
    check_eq("rst_sboxw", 128'(dif.sboxw), 128'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    expand_key(KEY128, 1'b0);
    run_op(C1_CT, 1'b0, 1'b1, 1'b0, KAT_PT);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_ready", 128'(dif.ready), 128'd1);
    check_eq("idle_hold", dif.new_block, KAT_PT);

    expand_key(KEY256, 1'b1);
    run_op(C3_CT, 1'b1, 1'b0, 1'b0, KAT_PT);

    expand_key(KEY128, 1'b0);
    run_op(C1_CT, 1'b0, 1'b0, 1'b1, KAT_PT);
    expand_key(KEY256, 1'b1);
    run_op(C3_CT, 1'b1, 1'b0, 1'b1, KAT_PT);

    dif.block  = C3_CT;
    dif.keylen = 1'b1;
    dif.next   = 1'b1;
    @(posedge clk); #1;
    dif.next = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check_eq("busy_pre_rst", 128'(dif.ready), 128'd0);
    reset_n = 1'b0;
    #1;
    check_eq("midop_rst_ready", 128'(dif.ready), 128'd1);
    check_eq("midop_rst_block", dif.new_block, 128'd0);
    check_eq("midop_rst_round", 128'(dif.round), 128'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    expand_key(KEY128, 1'b0);
    run_op(C1_CT, 1'b0, 1'b0, 1'b0, KAT_PT);

    for (int i = 0; i < 10; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      kl  = (i < 2) ? bit'(i) : bit'($urandom_range(0, 1));
      expand_key(key, kl);
      run_op(ct, kl, 1'b0, 1'b0, ref_decrypt(ct, kl));
      gap = (i < 2) ? 0 : $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
